rtc_timer_adj: RTL and testbench



---
 rtl/rtc_timer_adj.sv | 150 +++++++++++++++
 tb/tb_rtc_timer_adj.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timer_adj.sv
// RTC timer: seconds + ns.fraction counter advanced each clock by a programmable period,
// with a cycle-counted signed period adjustment and PPS strobe. Build option: RTC_DELTA_SIGMA_EN.
module rtc_timer_adj #(
    parameter int SEC_W   = 48,
    parameter int NS_W    = 30,
    parameter int TFRAC_W = 8,
    parameter int PNS_W   = 8,
    parameter int PFRAC_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       time_ld,
    input  logic [NS_W+TFRAC_W-1:0]    time_reg_ns_in,
    input  logic [SEC_W-1:0]           time_reg_sec_in,
    input  logic                       period_ld,
    input  logic [PNS_W+PFRAC_W-1:0]   period_in,
    input  logic [NS_W+TFRAC_W-1:0]    time_acc_modulo,
    input  logic                       adj_ld,
    input  logic [CNT_W-1:0]           adj_ld_data,
    input  logic [PNS_W+PFRAC_W-1:0]   period_adj,
    output logic [NS_W+TFRAC_W-1:0]    time_reg_ns,
    output logic [SEC_W-1:0]           time_reg_sec,
    output logic                       adj_busy,
    output logic                       pps_out
);

    localparam int TW     = NS_W + TFRAC_W;
    localparam int PW     = PNS_W + PFRAC_W;
    localparam int RES_W  = PFRAC_W - TFRAC_W;
    localparam int RES_RW = (RES_W > 0) ? RES_W : 1;
    localparam int SW     = TW + 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } adj_state_t;

    adj_state_t            state;
    logic [PW-1:0]         period_r;
    logic [PW-1:0]         adj_r;
    logic [CNT_W-1:0]      adj_cnt;

    logic signed [PW+1:0]  inc_sum;
    logic [PW:0]           inc_eff;
    logic [SW-1:0]         inc_upper;
    logic                  carry;
    logic [SW-1:0]         sum;
    logic                  wrap;
    logic [TW-1:0]         ns_next;

`ifdef RTC_DELTA_SIGMA_EN
    logic [RES_RW-1:0]     res;
    logic [RES_RW-1:0]     res_next;
    logic [RES_RW-1:0]     inc_low;
`endif

    always_comb begin
        inc_sum = $signed({2'b00, period_r});
        if (adj_busy)
            inc_sum = inc_sum + $signed({{2{adj_r[PW-1]}}, adj_r});
        // A non-positive increment freezes time rather than running it backward
        inc_eff   = inc_sum[PW+1] ? '0 : inc_sum[PW:0];
        inc_upper = SW'(inc_eff >> RES_W);
`ifdef RTC_DELTA_SIGMA_EN
        inc_low = (RES_W == 0) ? '0 : inc_eff[RES_RW-1:0];
        {carry, res_next} = {1'b0, res} + {1'b0, inc_low};
        if (RES_W == 0) begin
            carry    = 1'b0;
            res_next = '0;
        end
`else
        carry = 1'b0;
`endif
        sum     = {2'b00, time_reg_ns} + inc_upper + SW'(carry);
        wrap    = (sum >= {2'b00, time_acc_modulo});
        ns_next = wrap ? TW'(sum - {2'b00, time_acc_modulo}) : TW'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            period_r     <= '0;
            adj_r        <= '0;
            adj_cnt      <= '0;
            adj_busy     <= 1'b0;
            time_reg_ns  <= '0;
            time_reg_sec <= '0;
            pps_out      <= 1'b0;
`ifdef RTC_DELTA_SIGMA_EN
            res          <= '0;
`endif
        end else begin
            if (period_ld)
                period_r <= period_in;

            if (time_ld) begin
                time_reg_ns  <= time_reg_ns_in;
                time_reg_sec <= time_reg_sec_in;
                pps_out      <= 1'b0;
`ifdef RTC_DELTA_SIGMA_EN
                res          <= '0;
`endif
            end else begin
                time_reg_ns <= ns_next;
                if (wrap)
                    time_reg_sec <= time_reg_sec + 1'b1;
                pps_out <= wrap;
`ifdef RTC_DELTA_SIGMA_EN
                res     <= res_next;
`endif
            end

            // A coincident adj_ld wins over the time_ld abort so a fresh adjustment is never lost
            case (state)
                IDLE: begin
                    if (adj_ld && adj_ld_data != '0) begin
                        adj_r    <= period_adj;
                        adj_cnt  <= adj_ld_data;
                        state    <= ACTIVE;
                        adj_busy <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (adj_ld) begin
                        if (adj_ld_data != '0) begin
                            adj_r   <= period_adj;
                            adj_cnt <= adj_ld_data;
                        end else begin
                            adj_cnt  <= '0;
                            state    <= IDLE;
                            adj_busy <= 1'b0;
                        end
                    end else if (time_ld || adj_cnt == CNT_W'(1)) begin
                        adj_cnt  <= '0;
                        state    <= IDLE;
                        adj_busy <= 1'b0;
                    end else begin
                        adj_cnt <= adj_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    adj_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_timer_adj.sv
// Scoreboard bench for rtc_timer_adj: directed test-plan sequences then random loads,
// checked against an exact-precision time model. Honours RTC_DELTA_SIGMA_EN.
module tb_rtc_timer_adj;

    localparam int TW    = 38;
    localparam int PW    = 40;
    localparam int RES_W = 24;
    localparam logic [TW-1:0] MOD = 38'(64'd1000000000 << 8);

    logic            clk;
    logic            rst_n;
    logic            time_ld;
    logic [TW-1:0]   time_reg_ns_in;
    logic [47:0]     time_reg_sec_in;
    logic            period_ld;
    logic [PW-1:0]   period_in;
    logic [TW-1:0]   time_acc_modulo;
    logic            adj_ld;
    logic [31:0]     adj_ld_data;
    logic [PW-1:0]   period_adj;
    logic [TW-1:0]   time_reg_ns;
    logic [47:0]     time_reg_sec;
    logic            adj_busy;
    logic            pps_out;

    rtc_timer_adj #(
        .SEC_W(48), .NS_W(30), .TFRAC_W(8), .PNS_W(8), .PFRAC_W(32), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .time_ld(time_ld), .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
        .period_ld(period_ld), .period_in(period_in), .time_acc_modulo(time_acc_modulo),
        .adj_ld(adj_ld), .adj_ld_data(adj_ld_data), .period_adj(period_adj),
        .time_reg_ns(time_reg_ns), .time_reg_sec(time_reg_sec),
        .adj_busy(adj_busy), .pps_out(pps_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] ns;
        logic [47:0]   sec;
        logic          busy;
        logic          pps;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: time kept at full period precision (ns scaled by 2^32)
    logic [95:0]        m_fine;
    logic [47:0]        m_sec;
    logic [PW-1:0]      m_period;
    logic signed [PW-1:0] m_adj;
    longint             m_rem;
    logic               m_pps;

    task automatic model_reset();
        m_fine = '0; m_sec = '0; m_period = '0; m_adj = '0; m_rem = 0; m_pps = 1'b0;
    endtask

    task automatic step(input logic tl, input logic [TW-1:0] tns, input logic [47:0] tsec,
                        input logic pl, input logic [PW-1:0] pin,
                        input logic al, input logic [31:0] ad, input logic [PW-1:0] padj);
        longint inc;
        logic [95:0] add;
        logic [95:0] lim;
        exp_t e;
        time_ld = tl; time_reg_ns_in = tns; time_reg_sec_in = tsec;
        period_ld = pl; period_in = pin;
        adj_ld = al; adj_ld_data = ad; period_adj = padj;

        inc = longint'(m_period);
        if (m_rem > 0) inc = inc + longint'(m_adj);
        if (inc < 0) inc = 0;
`ifdef RTC_DELTA_SIGMA_EN
        add = 96'(inc);
`else
        add = 96'((inc >> RES_W) << RES_W);
`endif
        lim = 96'(MOD) << RES_W;
        if (tl) begin
            m_fine = 96'(tns) << RES_W;
            m_sec  = tsec;
            m_pps  = 1'b0;
        end else begin
            m_fine = m_fine + add;
            m_pps  = (m_fine >= lim);
            if (m_pps) begin
                m_fine = m_fine - lim;
                m_sec  = m_sec + 48'd1;
            end
        end
        if (m_rem > 0) m_rem = m_rem - 1;
        if (tl) m_rem = 0;
        if (al) begin
            m_rem = longint'(ad);
            if (ad != 0) m_adj = padj;
        end
        if (pl) m_period = pin;

        e.ns   = TW'(m_fine >> RES_W);
        e.sec  = m_sec;
        e.busy = (m_rem > 0);
        e.pps  = m_pps;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (time_reg_ns != '0 || time_reg_sec != '0 || adj_busy != 1'b0 || pps_out != 1'b0) begin
            n_bad++;
            $display("FAIL %s: got ns=%0d sec=%0d busy=%0b pps=%0b, want all 0",
                     name, time_reg_ns, time_reg_sec, adj_busy, pps_out);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop one expectation per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (time_reg_ns !== e.ns || time_reg_sec !== e.sec ||
                    adj_busy !== e.busy || pps_out !== e.pps) begin
                    n_bad++;
                    $display("FAIL cycle @%0t: got ns=%0d sec=%0d busy=%0b pps=%0b, want ns=%0d sec=%0d busy=%0b pps=%0b",
                             $time, time_reg_ns, time_reg_sec, adj_busy, pps_out,
                             e.ns, e.sec, e.busy, e.pps);
                end
            end
        end
    end

    localparam logic [PW-1:0] P8   = 40'h08_0000_0000;
    localparam logic [PW-1:0] A2   = 40'h02_0000_0000;
    localparam logic [PW-1:0] AM10 = 40'hF6_0000_0000;

    initial begin
        longint pv;
        logic [TW-1:0] tns;
        rst_n = 1'b0;
        time_ld = 1'b0; time_reg_ns_in = '0; time_reg_sec_in = '0;
        period_ld = 1'b0; period_in = '0; time_acc_modulo = MOD;
        adj_ld = 1'b0; adj_ld_data = '0; period_adj = '0;
        model_reset();
        #23;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Period 0 after reset: time holds
        idle(3);
        // Rollover across one second
        step(1'b0, '0, '0, 1'b1, P8, 1'b0, '0, '0);
        step(1'b1, 38'(64'd999999990 << 8), 48'd10, 1'b0, '0, 1'b0, '0, '0);
        idle(4);
        // Sub-LSB period fraction over 8 cycles
        step(1'b1, '0, '0, 1'b1, 40'h08_1020_0000, 1'b0, '0, '0);
        idle(8);
        // +2 ns for 10 cycles
        step(1'b1, '0, '0, 1'b1, P8, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd10, A2);
        idle(13);
        // -10 ns for 5 cycles: frozen
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd5, AM10);
        idle(8);
        // Count 0, restart while active, abort by time_ld
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd0, A2);
        idle(2);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd6, A2);
        idle(3);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd4, AM10);
        idle(2);
        step(1'b1, 38'd12345, 48'd7, 1'b0, '0, 1'b0, '0, '0);
        idle(2);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd9, A2);
        idle(2);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd0, A2);
        idle(2);
        // Reset mid-adjustment, then hold until period_ld
        step(1'b1, MOD - 38'd100, 48'd3, 1'b0, '0, 1'b1, 32'd20, A2);
        idle(3);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        step(1'b0, '0, '0, 1'b1, P8, 1'b0, '0, '0);
        idle(3);

        // Randomised phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0)
                tns = MOD - 38'($urandom_range(1, 3000));
            else
                tns = 38'((longint'($urandom) << 6) % longint'(MOD));
            pv = (longint'($urandom) & 64'h3F_FFFF_FFFF) - 64'h20_0000_0000;
            if ($urandom_range(0, 15) == 0)
                pv = -(longint'($urandom_range(1, 40)) << 32);
            step($urandom_range(0, 40) == 0, tns, 48'($urandom),
                 $urandom_range(0, 30) == 0, {8'($urandom_range(0, 20)), 32'($urandom)},
                 $urandom_range(0, 20) == 0, 32'($urandom_range(0, 12)), 40'(pv));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
